// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register-file write-port arbiter between the pipeline
//                writeback stage and a long-latency unit (divider).
//                Long-latency results are held in a 2-entry FIFO until the
//                port is free. A starvation counter stalls the pipeline for
//                one cycle so the FIFO head can drain.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  // pipeline writeback stage
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [1:0]  pipe_WDSel,
  input  logic [31:0] pipe_aluout,
  input  logic [31:0] pipe_dout,
  input  logic [31:0] pipe_PC,
  // long-latency unit
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  // decode-stage hazard check
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        stall_pipe,
  // register-file write port
  output logic        RFWr,
  output logic [4:0]  rf_rd,
  output logic [31:0] WD
);

  // Counter must be wide enough to hold STARVE_MAX itself.
  localparam int C_STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_MAX);

  // FIFO storage: two slots addressed by a 1-bit head pointer.
  logic [4:0]            fifo_rd_q   [2];
  logic [4:0]            fifo_rd_d   [2];
  logic [31:0]           fifo_data_q [2];
  logic [31:0]           fifo_data_d [2];
  logic                  head_q, head_d;
  logic [1:0]            count_q, count_d;
  logic [C_STARVE_W-1:0] starve_q, starve_d;

  // Registered write port.
  logic                  rf_wr_q, rf_wr_d;
  logic [4:0]            rf_rd_q, rf_rd_d;
  logic [31:0]           wd_q, wd_d;

  // Combinational decision signals.
  logic [31:0] w_pipe_data;
  logic        w_pipe_req;
  logic        w_fifo_empty;
  logic        w_lu_ready;
  logic        w_stall;
  logic        w_pop;
  logic        w_grant_pipe;
  logic        w_bypass;
  logic        w_push;
  logic        w_wr_idx;
  logic [1:0]  w_ent_valid;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic        w_hazard;

  // True when a non-zero source register matches any pending destination.
  function automatic logic src_hit(
    input logic [4:0] r,
    input logic [1:0] ent_valid,
    input logic [4:0] rd0,
    input logic [4:0] rd1,
    input logic       push,
    input logic [4:0] push_rd
  );
    logic hit;
    hit = (ent_valid[0] && (rd0 == r)) ||
          (ent_valid[1] && (rd1 == r)) ||
          (push && (push_rd == r));
    return (r != 5'd0) && hit;
  endfunction

  // Pipeline writeback operand select; the reserved encoding never writes.
  always_comb begin
    w_pipe_data = pipe_aluout;
    case (pipe_WDSel)
      2'b01:   w_pipe_data = pipe_dout;
      2'b10:   w_pipe_data = pipe_PC + 32'd4;
      default: w_pipe_data = pipe_aluout;
    endcase
  end

  // Write-port grant: forced drain, then pipeline, then FIFO, then bypass.
  always_comb begin
    w_fifo_empty = (count_q == 2'd0);
    w_pipe_req   = pipe_valid && (pipe_rd != 5'd0) && (pipe_WDSel != 2'b11);
    w_lu_ready   = !rst && (count_q != 2'd2);
    w_stall      = !rst && (starve_q == C_STARVE_MAX);
    w_pop        = 1'b0;
    w_grant_pipe = 1'b0;
    w_bypass     = 1'b0;
    if (!rst) begin
      if (w_stall) begin
        w_pop = 1'b1;
      end else if (w_pipe_req) begin
        w_grant_pipe = 1'b1;
      end else if (!w_fifo_empty) begin
        w_pop = 1'b1;
      end else if (lu_valid && (lu_rd != 5'd0)) begin
        w_bypass = 1'b1;
      end
    end
    // rd=0 results complete the handshake but are dropped; bypassed ones
    // go straight to the port and are not buffered.
    w_push = lu_valid && w_lu_ready && (lu_rd != 5'd0) && !w_bypass;
  end

  // Entry occupancy, head read-out and hazard detection.
  always_comb begin
    w_ent_valid[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b0));
    w_ent_valid[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b1));
    w_head_rd      = fifo_rd_q[head_q];
    w_head_data    = fifo_data_q[head_q];
    w_hazard       = !rst &&
                     (src_hit(rs1, w_ent_valid, fifo_rd_q[0], fifo_rd_q[1], w_push, lu_rd) ||
                      src_hit(rs2, w_ent_valid, fifo_rd_q[0], fifo_rd_q[1], w_push, lu_rd));
  end

  // FIFO next state: tail slot is head offset by the occupancy.
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    head_d      = head_q;
    count_d     = count_q;
    w_wr_idx    = head_q ^ count_q[0];
    if (w_push) begin
      fifo_rd_d[w_wr_idx]   = lu_rd;
      fifo_data_d[w_wr_idx] = lu_data;
    end
    if (w_pop) begin
      head_d = ~head_q;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (rst) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end
  end

  // Starvation counter: counts cycles the head waits, saturating.
  always_comb begin
    starve_d = starve_q;
    if (rst || w_fifo_empty || w_pop) begin
      starve_d = '0;
    end else if (starve_q != C_STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Write-port next state; address/data hold when nothing is granted.
  always_comb begin
    rf_wr_d = 1'b0;
    rf_rd_d = rf_rd_q;
    wd_d    = wd_q;
    if (rst) begin
      rf_rd_d = 5'd0;
      wd_d    = 32'd0;
    end else if (w_pop) begin
      rf_wr_d = 1'b1;
      rf_rd_d = w_head_rd;
      wd_d    = w_head_data;
    end else if (w_grant_pipe) begin
      rf_wr_d = 1'b1;
      rf_rd_d = pipe_rd;
      wd_d    = w_pipe_data;
    end else if (w_bypass) begin
      rf_wr_d = 1'b1;
      rf_rd_d = lu_rd;
      wd_d    = lu_data;
    end
  end

  // State registers; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
    head_q      <= head_d;
    count_q     <= count_d;
    starve_q    <= starve_d;
    rf_wr_q     <= rf_wr_d;
    rf_rd_q     <= rf_rd_d;
    wd_q        <= wd_d;
  end

  assign lu_ready   = w_lu_ready;
  assign stall_pipe = w_stall;
  assign hazard     = w_hazard;
  assign RFWr       = rf_wr_q;
  assign rf_rd      = rf_rd_q;
  assign WD         = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: directed scenarios with
//                literal expectations, then randomized traffic compared each
//                cycle against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [1:0]  pipe_WDSel;
  logic [31:0] pipe_aluout, pipe_dout, pipe_PC;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs1, rs2;
  logic        hazard, stall_pipe, RFWr;
  logic [4:0]  rf_rd;
  logic [31:0] WD;

  wb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_WDSel(pipe_WDSel),
    .pipe_aluout(pipe_aluout), .pipe_dout(pipe_dout), .pipe_PC(pipe_PC),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard), .stall_pipe(stall_pipe),
    .RFWr(RFWr), .rf_rd(rf_rd), .WD(WD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        fq[$];
  int          starve = 0;
  logic        e_wr = 1'b0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_wd = 32'd0;
  // per-cycle decisions: grant 0=none 1=pipe 2=fifo head 3=bypass
  int          m_g;
  bit          m_push, m_ready, m_stall, m_haz;

  function automatic logic [31:0] pipe_word();
    case (pipe_WDSel)
      2'b01:   return pipe_dout;
      2'b10:   return pipe_PC + 32'd4;
      default: return pipe_aluout;
    endcase
  endfunction

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (fq[i]) if (fq[i].rd == r) return 1'b1;
    return m_push && (lu_rd == r);
  endfunction

  task automatic model_eval();
    int  n;
    bit  pipe_ok;
    n       = fq.size();
    pipe_ok = pipe_valid && (pipe_rd != 5'd0) && (pipe_WDSel != 2'b11);
    m_ready = !rst && (n < 2);
    m_stall = !rst && (starve == SMAX);
    m_g     = 0;
    m_push  = 1'b0;
    if (!rst) begin
      if (m_stall)                          m_g = 2;
      else if (pipe_ok)                     m_g = 1;
      else if (n > 0)                       m_g = 2;
      else if (lu_valid && lu_rd != 5'd0)   m_g = 3;
      m_push = lu_valid && m_ready && (lu_rd != 5'd0) && (m_g != 3);
    end
    m_haz = !rst && (pending(rs1) || pending(rs2));
  endtask

  // Advance the model on each rising edge using the inputs held there.
  always @(posedge clk) begin
    int   n0;
    ent_t h;
    if (rst) begin
      fq.delete();
      starve = 0;
      e_wr = 1'b0; e_rd = 5'd0; e_wd = 32'd0;
    end else begin
      model_eval();
      n0 = fq.size();
      e_wr = 1'b1;
      case (m_g)
        1: begin e_rd = pipe_rd; e_wd = pipe_word(); end
        2: begin h = fq.pop_front(); e_rd = h.rd; e_wd = h.d; end
        3: begin e_rd = lu_rd; e_wd = lu_data; end
        default: e_wr = 1'b0;
      endcase
      if (m_push) fq.push_back('{rd: lu_rd, d: lu_data});
      if (n0 == 0 || m_g == 2) starve = 0;
      else if (starve < SMAX)  starve = starve + 1;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      model_eval();
      chk("m_lu_ready", lu_ready, m_ready);
      chk("m_stall", stall_pipe, m_stall);
      chk("m_hazard", hazard, m_haz);
      chk("m_RFWr", RFWr, e_wr);
      chk("m_rf_rd", rf_rd, e_rd);
      chk("m_WD", WD, e_wd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    pipe_valid = 0; pipe_rd = 0; pipe_WDSel = 0;
    pipe_aluout = 0; pipe_dout = 0; pipe_PC = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = 1; pipe_rd = rd; pipe_WDSel = 2'b00; pipe_aluout = d;
  endtask

  initial begin
    int         nlu;
    logic [4:0] seen_rd [2];
    logic [31:0] seen_d [2];

    idle();
    // Reset: outputs quiet and offered lu results refused.
    lu(1, 5'd6, 32'h66); rs1 = 5'd6;
    @(negedge clk);
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_stall", stall_pipe, 0);
    chk("rst_hazard", hazard, 0);
    tick();
    chk("rst_RFWr", RFWr, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_WD", WD, 0);
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;

    // PC+4 wraps modulo 2^32.
    idle();
    pipe_valid = 1; pipe_rd = 5'd5; pipe_WDSel = 2'b10; pipe_PC = 32'hFFFF_FFFC;
    tick();
    chk("pc4_RFWr", RFWr, 1);
    chk("pc4_rf_rd", rf_rd, 5);
    chk("pc4_WD", WD, 32'h0);

    // Bypass with empty FIFO.
    idle(); lu(1, 5'd7, 32'h1234);
    @(negedge clk);
    chk("byp_lu_ready", lu_ready, 1);
    tick();
    chk("byp_RFWr", RFWr, 1);
    chk("byp_rf_rd", rf_rd, 7);
    chk("byp_WD", WD, 32'h1234);
    idle(); rs1 = 5'd7;
    @(negedge clk);
    chk("byp_no_hazard", hazard, 0);
    tick();
    chk("byp_not_buffered", RFWr, 0);
    chk("byp_rd_hold", rf_rd, 7);

    // Starvation: one buffered result drained by a one-cycle stall.
    idle(); pipe_alu(5'd3, 32'hAAAA); lu(1, 5'd9, 32'h99);
    tick();
    chk("st_pipe_first", rf_rd, 3);
    lu(0, 0, 0); rs1 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_wait_stall", stall_pipe, 0);
      chk("st_wait_hazard", hazard, 1);
      tick();
      chk("st_wait_rd", rf_rd, 3);
    end
    @(negedge clk);
    chk("st_stall", stall_pipe, 1);
    tick();
    chk("st_drain_wr", RFWr, 1);
    chk("st_drain_rd", rf_rd, 9);
    chk("st_drain_wd", WD, 32'h99);
    @(negedge clk);
    chk("st_stall_clear", stall_pipe, 0);
    chk("st_hazard_clear", hazard, 0);
    tick();
    chk("st_pipe_resume", rf_rd, 3);

    // Two buffered results: full FIFO, hazard, ordered drain.
    lu(1, 5'd11, 32'hB1); tick();
    lu(1, 5'd12, 32'hB2); tick();
    lu(1, 5'd15, 32'hF5); rs1 = 5'd11;
    @(negedge clk);
    chk("full_lu_ready", lu_ready, 0);
    chk("full_hazard", hazard, 1);
    tick();
    lu(0, 0, 0);
    nlu = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (RFWr && rf_rd != 5'd3) begin
        if (nlu < 2) begin seen_rd[nlu] = rf_rd; seen_d[nlu] = WD; end
        nlu++;
      end
    end
    chk("full_drain_count", nlu, 2);
    chk("full_first_rd", seen_rd[0], 11);
    chk("full_first_wd", seen_d[0], 32'hB1);
    chk("full_second_rd", seen_rd[1], 12);
    chk("full_second_wd", seen_d[1], 32'hB2);
    rs1 = 5'd11; rs2 = 5'd12;
    @(negedge clk);
    chk("full_after_hazard", hazard, 0);
    chk("full_after_ready", lu_ready, 1);
    tick();

    // lu_rd=0 accepted and discarded; reserved WDSel writes nothing.
    idle();
    pipe_valid = 1; pipe_rd = 5'd4; pipe_WDSel = 2'b11; lu(1, 5'd0, 32'h5555);
    @(negedge clk);
    chk("rd0_lu_ready", lu_ready, 1);
    tick();
    chk("rd0_RFWr", RFWr, 0);
    idle();
    tick();
    chk("rd0_not_buffered", RFWr, 0);

    // Reset with two buffered entries discards them.
    pipe_alu(5'd3, 32'h33);
    lu(1, 5'd13, 32'hD3); tick();
    lu(1, 5'd14, 32'hD4); tick();
    lu(0, 0, 0);
    @(negedge clk);
    chk("rf_full_ready", lu_ready, 0);
    rst = 1'b1;
    tick();
    chk("rf_RFWr", RFWr, 0);
    chk("rf_rf_rd", rf_rd, 0);
    rst = 1'b0; idle();
    @(negedge clk);
    chk("rf_ready", lu_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rf_no_write", RFWr, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      pipe_valid  = ($urandom_range(0, 9) < 7);
      pipe_rd     = 5'($urandom_range(0, 7));
      pipe_WDSel  = 2'($urandom);
      pipe_aluout = $urandom;
      pipe_dout   = $urandom;
      pipe_PC     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      lu_valid    = ($urandom_range(0, 9) < 4);
      lu_rd       = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      tick();
    end

    rst = 1'b0; idle();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
